// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage controller and the data memory.
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues loads/stores over a req/ack bus, stalls while they are
// outstanding, aligns and extends load data and registers the MEM/WB outputs.
module mem_stage_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        dest,
  input  logic [1:0]        memwrite,
  input  logic [1:0]        memread,
  input  logic              memtoreg,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [31:0]       store_data,
  input  logic              ld_unsigned,
  mem_stage_ctrl_if.master  bus,
  output logic              mem_stall,
  output logic [4:0]        wb_dest,
  output logic [31:0]       wb_data,
  output logic              wb_memtoreg,
  output logic              wb_valid,
  output logic              mem_err
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [4:0]        dest_reg;
  logic              memtoreg_reg;
  logic [1:0]        lane_reg;
  logic [1:0]        size_reg;
  logic              unsigned_reg;
  logic [31:0]       alu_reg;
  logic [31:0]       rdata_reg;

  logic [31:0] alu_lo;
  logic        has_op, illegal, misaligned, start;
  logic [1:0]  size;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] done_data;

  generate
    if (ADDR_W >= 32) begin : g_alu_wide
      assign alu_lo = alu_result[31:0];
    end else begin : g_alu_narrow
      assign alu_lo = {{(32-ADDR_W){1'b0}}, alu_result};
    end
  endgenerate

  // Only one of memwrite/memread is nonzero for a legal op, so OR-ing gives the size.
  assign has_op     = (memwrite != 2'b00) || (memread != 2'b00);
  assign illegal    = (memwrite != 2'b00) && (memread != 2'b00);
  assign size       = memwrite | memread;
  assign misaligned = ((size == 2'b10) && alu_result[0]) ||
                      ((size == 2'b11) && (alu_result[1:0] != 2'b00));
  assign start      = (state_reg == IDLE) && has_op && !illegal && !misaligned;
  assign mem_stall  = (state_reg == WAIT) || start;

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = store_data;
    case (size)
      2'b01: begin
        be_next    = 4'b0001 << alu_result[1:0];
        wdata_next = {4{store_data[7:0]}};
      end
      2'b10: begin
        be_next    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{store_data[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = store_data;
      end
    endcase
  end

  always_comb begin
    byte_sel  = rdata_reg[{lane_reg, 3'b000} +: 8];
    half_sel  = lane_reg[1] ? rdata_reg[31:16] : rdata_reg[15:0];
    load_data = rdata_reg;
    case (size_reg)
      2'b01:   load_data = unsigned_reg ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b10:   load_data = unsigned_reg ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rdata_reg;
    endcase
    done_data = bus.dmem_we ? alu_reg : load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      dest_reg       <= '0;
      memtoreg_reg   <= 1'b0;
      lane_reg       <= '0;
      size_reg       <= '0;
      unsigned_reg   <= 1'b0;
      alu_reg        <= '0;
      rdata_reg      <= '0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_be    <= '0;
      bus.dmem_wdata <= '0;
      wb_dest        <= '0;
      wb_data        <= '0;
      wb_memtoreg    <= 1'b0;
      wb_valid       <= 1'b0;
      mem_err        <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!has_op) begin
            wb_dest     <= dest;
            wb_data     <= alu_lo;
            wb_memtoreg <= memtoreg;
            wb_valid    <= 1'b1;
          end else begin
            wb_dest     <= '0;
            wb_data     <= '0;
            wb_memtoreg <= 1'b0;
            wb_valid    <= 1'b0;
            if (illegal || misaligned) begin
              mem_err <= 1'b1;
            end else begin
              dest_reg       <= dest;
              memtoreg_reg   <= memtoreg;
              lane_reg       <= alu_result[1:0];
              size_reg       <= size;
              unsigned_reg   <= ld_unsigned;
              alu_reg        <= alu_lo;
              bus.dmem_req   <= 1'b1;
              bus.dmem_we    <= (memwrite != 2'b00);
              bus.dmem_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
              bus.dmem_be    <= be_next;
              bus.dmem_wdata <= wdata_next;
              cnt_reg        <= '0;
              state_reg      <= WAIT;
            end
          end
        end
        WAIT: begin
          wb_dest     <= '0;
          wb_data     <= '0;
          wb_memtoreg <= 1'b0;
          wb_valid    <= 1'b0;
          if (bus.dmem_ack) begin
            bus.dmem_req <= 1'b0;
            rdata_reg    <= bus.dmem_rdata;
            state_reg    <= DONE;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            // Abort: the op stays in EX/MEM and is re-presented in IDLE.
            bus.dmem_req <= 1'b0;
            mem_err      <= 1'b1;
            state_reg    <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          wb_dest     <= dest_reg;
          wb_data     <= done_data;
          wb_memtoreg <= memtoreg_reg;
          wb_valid    <= 1'b1;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: single-cycle vector table plus multi-cycle access sequences.
module tb_mem_stage_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  dest;
  logic [1:0]  memwrite, memread;
  logic        memtoreg;
  logic [31:0] alu_result, store_data;
  logic        ld_unsigned;
  logic        mem_stall;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        wb_memtoreg, wb_valid, mem_err;

  int errors = 0;
  int checks = 0;

  mem_stage_ctrl_if #(.ADDR_W(32)) bus ();

  mem_stage_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .dest(dest), .memwrite(memwrite), .memread(memread),
    .memtoreg(memtoreg), .alu_result(alu_result), .store_data(store_data),
    .ld_unsigned(ld_unsigned), .bus(bus), .mem_stall(mem_stall), .wb_dest(wb_dest),
    .wb_data(wb_data), .wb_memtoreg(wb_memtoreg), .wb_valid(wb_valid), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dest;
    logic [1:0]  mw, mr;
    logic        mtr;
    logic [31:0] alu;
    logic [4:0]  e_dest;
    logic [31:0] e_data;
    logic        e_mtr, e_valid, e_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] d, input logic [1:0] mw, input logic [1:0] mr,
                       input logic mtr, input logic [31:0] a, input logic [31:0] sd,
                       input logic lu);
    dest = d; memwrite = mw; memread = mr; memtoreg = mtr;
    alu_result = a; store_data = sd; ld_unsigned = lu;
  endtask

  task automatic mem_op(input string nm, input logic [4:0] d, input logic [1:0] mw,
                        input logic [1:0] mr, input logic mtr, input logic [31:0] a,
                        input logic [31:0] sd, input logic lu, input int ack_at,
                        input logic [31:0] rd, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic [31:0] e_wb,
                        input int e_stall);
    int stalls = 0;
    drive(d, mw, mr, mtr, a, sd, lu);
    #1;
    if (mem_stall) stalls++;
    @(posedge clk); #1;
    chk({nm, " req"}, 32'(bus.dmem_req), 32'd1);
    chk({nm, " we"}, 32'(bus.dmem_we), 32'(mw != 2'b00));
    chk({nm, " addr"}, bus.dmem_addr, {a[31:2], 2'b00});
    chk({nm, " be"}, 32'(bus.dmem_be), 32'(e_be));
    if (mw != 2'b00) chk({nm, " wdata"}, bus.dmem_wdata, e_wdata);
    chk({nm, " bubble"}, 32'(wb_valid), 32'd0);
    for (int k = 1; k <= ack_at; k++) begin
      if (mem_stall) stalls++;
      chk({nm, " req held"}, 32'(bus.dmem_req), 32'd1);
      if (k == ack_at) begin
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = rd;
      end
      @(posedge clk); #1;
      bus.dmem_ack = 1'b0;
    end
    chk({nm, " stall cycles"}, 32'(stalls), 32'(e_stall));
    chk({nm, " done stall"}, 32'(mem_stall), 32'd0);
    chk({nm, " req drop"}, 32'(bus.dmem_req), 32'd0);
    @(posedge clk); #1;
    chk({nm, " wb_valid"}, 32'(wb_valid), 32'd1);
    chk({nm, " wb_dest"}, 32'(wb_dest), 32'(d));
    chk({nm, " wb_data"}, wb_data, e_wb);
    chk({nm, " wb_memtoreg"}, 32'(wb_memtoreg), 32'(mtr));
    chk({nm, " mem_err"}, 32'(mem_err), 32'd0);
    $display("op %s: wb_data=%h stalls=%0d", nm, wb_data, stalls);
    drive(5'd0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " req"}, 32'(bus.dmem_req), 32'd0);
    chk({nm, " we"}, 32'(bus.dmem_we), 32'd0);
    chk({nm, " addr"}, bus.dmem_addr, 32'd0);
    chk({nm, " be"}, 32'(bus.dmem_be), 32'd0);
    chk({nm, " wdata"}, bus.dmem_wdata, 32'd0);
    chk({nm, " wb_dest"}, 32'(wb_dest), 32'd0);
    chk({nm, " wb_data"}, wb_data, 32'd0);
    chk({nm, " wb_memtoreg"}, 32'(wb_memtoreg), 32'd0);
    chk({nm, " wb_valid"}, 32'(wb_valid), 32'd0);
    chk({nm, " mem_err"}, 32'(mem_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            dest  mw     mr     mtr  alu           e_dest e_data        e_mtr e_val e_err
    vecs[0] = '{5'd5,  2'b00, 2'b00, 1'b0, 32'h0000_1234, 5'd5,  32'h0000_1234, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{5'd31, 2'b00, 2'b00, 1'b1, 32'hFFFF_0000, 5'd31, 32'hFFFF_0000, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{5'd9,  2'b00, 2'b11, 1'b1, 32'h0000_0101, 5'd0,  32'h0,         1'b0, 1'b0, 1'b1};
    vecs[3] = '{5'd4,  2'b00, 2'b00, 1'b0, 32'h0000_0042, 5'd4,  32'h0000_0042, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{5'd6,  2'b10, 2'b00, 1'b0, 32'h0000_0203, 5'd0,  32'h0,         1'b0, 1'b0, 1'b1};
    vecs[5] = '{5'd7,  2'b01, 2'b01, 1'b1, 32'h0000_0100, 5'd0,  32'h0,         1'b0, 1'b0, 1'b1};
    vecs[6] = '{5'd8,  2'b00, 2'b10, 1'b1, 32'h0000_0201, 5'd0,  32'h0,         1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = 32'h0;
    drive(5'd0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    $display("reset: outputs cleared");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].dest, vecs[i].mw, vecs[i].mr, vecs[i].mtr, vecs[i].alu, 32'h0, 1'b0);
      #1;
      chk($sformatf("vec%0d stall", i), 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d req", i), 32'(bus.dmem_req), 32'd0);
      chk($sformatf("vec%0d wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d wb_dest", i), 32'(wb_dest), 32'(vecs[i].e_dest));
      chk($sformatf("vec%0d wb_memtoreg", i), 32'(wb_memtoreg), 32'(vecs[i].e_mtr));
      chk($sformatf("vec%0d mem_err", i), 32'(mem_err), 32'(vecs[i].e_err));
      if (vecs[i].e_valid) chk($sformatf("vec%0d wb_data", i), wb_data, vecs[i].e_data);
      $display("vec %0d: wb_valid=%0d wb_dest=%0d wb_data=%h mem_err=%0d",
               i, wb_valid, wb_dest, wb_data, mem_err);
    end

    //     name          dest  mw     mr     mtr   addr          sdata         lu    ack rdata         be       wdata         wb            stalls
    mem_op("lw",         5'd7, 2'b00, 2'b11, 1'b1, 32'h0000_0100, 32'h0,        1'b0, 2, 32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF, 3);
    mem_op("lb",         5'd8, 2'b00, 2'b01, 1'b1, 32'h0000_0103, 32'h0,        1'b0, 1, 32'h80FF0000, 4'b1000, 32'h0,        32'hFFFFFF80, 2);
    mem_op("lbu",        5'd9, 2'b00, 2'b01, 1'b1, 32'h0000_0103, 32'h0,        1'b1, 1, 32'h80FF0000, 4'b1000, 32'h0,        32'h00000080, 2);
    mem_op("sh",         5'd0, 2'b10, 2'b00, 1'b0, 32'h0000_0202, 32'hABCD1234, 1'b0, 1, 32'h0,        4'b1100, 32'h12341234, 32'h00000202, 2);
    mem_op("lh",         5'd3, 2'b00, 2'b10, 1'b1, 32'h0000_0202, 32'h0,        1'b0, 3, 32'h80017FFF, 4'b1100, 32'h0,        32'hFFFF8001, 4);
    mem_op("lhu_lo",     5'd4, 2'b00, 2'b10, 1'b1, 32'h0000_0200, 32'h0,        1'b1, 1, 32'h80019234, 4'b0011, 32'h0,        32'h00009234, 2);
    mem_op("sb",         5'd2, 2'b01, 2'b00, 1'b0, 32'h0000_0101, 32'h0000005A, 1'b0, 1, 32'h0,        4'b0010, 32'h5A5A5A5A, 32'h00000101, 2);

    // Timeout: four WAIT cycles without ack, then abort.
    drive(5'd10, 2'b00, 2'b11, 1'b1, 32'h0000_0300, 32'h0, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("timeout req wait%0d", k), 32'(bus.dmem_req), 32'd1);
      chk($sformatf("timeout stall wait%0d", k), 32'(mem_stall), 32'd1);
      chk($sformatf("timeout err wait%0d", k), 32'(mem_err), 32'd0);
      @(posedge clk); #1;
    end
    chk("timeout req drop", 32'(bus.dmem_req), 32'd0);
    chk("timeout mem_err", 32'(mem_err), 32'd1);
    chk("timeout bubble", 32'(wb_valid), 32'd0);
    drive(5'd0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk("timeout err pulse", 32'(mem_err), 32'd0);
    $display("timeout: access aborted");

    // Reset while WAIT, then a stray ack must be ignored.
    drive(5'd11, 2'b11, 2'b00, 1'b0, 32'h0000_0404, 32'hCAFEF00D, 1'b0);
    @(posedge clk); #1;
    chk("rstwait req", 32'(bus.dmem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_zero("rstwait");
    rst = 1'b0;
    drive(5'd3, 2'b00, 2'b00, 1'b0, 32'h0000_0055, 32'h0, 1'b0);
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h1111_2222;
    #1;
    chk("late ack stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    bus.dmem_ack = 1'b0;
    chk("late ack req", 32'(bus.dmem_req), 32'd0);
    chk("late ack wb_valid", 32'(wb_valid), 32'd1);
    chk("late ack wb_data", wb_data, 32'h0000_0055);
    chk("late ack wb_dest", 32'(wb_dest), 32'd3);
    $display("reset in wait: late ack ignored, wb_data=%h", wb_data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
MEM-stage responder that consumes the EX/MEM pipeline register outputs (dest, memwrite, memread, memtoreg, ALU result, store data). It runs the data-memory access over a req/ack bus, stalls the pipeline while the access is outstanding, aligns and extends load data, and registers the MEM/WB outputs. Non-memory instructions pass through with 1-cycle latency.

Parameters:
ADDR_W, 32, width of the ALU result and the memory address
TIMEOUT, 15, maximum WAIT cycles without dmem_ack before the access is aborted (≥1)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
dest  input  5  destination register from EX/MEM
memwrite  input  2  store size: 00 none, 01 byte, 10 half, 11 word
memread  input  2  load size: same encoding as memwrite
memtoreg  input  1  writeback selects memory data
alu_result  input  ADDR_W  ALU result / effective address
store_data  input  32  rt value to store
ld_unsigned  input  1  1 = zero-extend byte/half loads; 0 = sign-extend
dmem_req  output  1  bus request, registered
dmem_we  output  1  1 = write
dmem_addr  output  ADDR_W  word-aligned address (low two bits 0)
dmem_be  output  4  byte enables, bit k = byte lane k (little-endian)
dmem_wdata  output  32  store data replicated across lanes
dmem_rdata  input  32  read data, valid with dmem_ack
dmem_ack  input  1  single-cycle completion pulse
mem_stall  output  1  combinational; hold the PC, IF/ID, ID/EX and EX/MEM
wb_dest  output  5  MEM/WB destination
wb_data  output  32  MEM/WB data (loaded value or alu_result[31:0])
wb_memtoreg  output  1  MEM/WB memtoreg
wb_valid  output  1  MEM/WB entry is a real instruction
mem_err  output  1  registered 1-cycle pulse on a misaligned, illegal or timed-out access

Behaviour:
- Reset: state IDLE; every output register 0 (dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_dest, wb_data, wb_memtoreg, wb_valid, mem_err); timeout counter 0.
- States: IDLE, WAIT, DONE.
- op = (memwrite!=0) or (memread!=0).
- Illegal: both memwrite and memread are nonzero.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- IDLE with no op:
  - next cycle: wb_dest=dest, wb_data=alu_result, wb_memtoreg=memtoreg, wb_valid=1.
  - mem_stall=0.
- IDLE with an illegal or misaligned op:
  - no bus access; mem_stall=0.
  - next cycle: MEM/WB bubble (wb_valid=0, wb_dest=0, wb_memtoreg=0); mem_err=1 for one cycle.
- IDLE with a legal op:
  - mem_stall=1; MEM/WB bubble on the next edge.
  - Latch dmem_addr={addr[ADDR_W-1:2],2'b00}, dmem_we, dmem_be, dmem_wdata, dest, memtoreg, lane, size and ld_unsigned.
  - Set dmem_req=1; go to WAIT; clear the counter.
- Byte enables and write data:
  - byte: be=1<<addr[1:0], wdata={4{store_data[7:0]}}.
  - half: be=addr[1]?1100:0011, wdata={2{store_data[15:0]}}.
  - word: be=1111, wdata=store_data.
- WAIT:
  - mem_stall=1; dmem_req held at 1; bus outputs stable.
  - On dmem_ack: drop dmem_req; capture dmem_rdata; go to DONE.
  - Without ack: counter++. When counter==TIMEOUT-1 without ack, drop dmem_req, pulse mem_err, write a bubble, go to IDLE.
  - Bubble written to MEM/WB each WAIT cycle.
- DONE:
  - mem_stall=0 so EX/MEM advances; the held op is consumed here and not re-issued.
  - Next edge: wb_dest, wb_memtoreg, wb_valid=1.
  - wb_data: for a load, the captured lane extracted (byte lane addr[1:0]; half lane addr[1]) and sign- or zero-extended per ld_unsigned; for a store, the latched alu_result.
  - Go to IDLE.
- Latency: non-mem op 1 cycle. Mem op with ack in the first WAIT cycle: 3 cycles (IDLE, WAIT, DONE), of which mem_stall is high for 2.
- dmem_ack in IDLE or DONE: ignored.
- Reset in WAIT: dmem_req=0 on the reset edge; a late ack is ignored.
- ADDR_W>32: wb_data takes alu_result[31:0].

Test Plan:
- Non-mem op: dest=5, alu_result=0x1234 → next cycle wb_dest=5, wb_data=0x1234, wb_valid=1, mem_stall never 1.
- Word load: addr=0x100, ack after 2 WAIT cycles, rdata=0xDEADBEEF → dmem_addr=0x100, be=1111, mem_stall high 3 cycles, then wb_data=0xDEADBEEF.
- Byte load: addr=0x103, rdata=0x80FF0000, ld_unsigned=0 → be=1000, wb_data=0xFFFFFF80; repeat with ld_unsigned=1 → 0x00000080.
- Half store: addr=0x202, store_data=0xABCD1234 → dmem_we=1, be=1100, wdata=0x12341234, dmem_addr=0x200.
- Misaligned word load at 0x101 → no dmem_req; mem_err pulse; wb_valid=0; mem_stall=0.
- Timeout with no ack for TIMEOUT=4 cycles → mem_err; dmem_req falls. Separately, rst in WAIT → all outputs 0 next cycle and a following ack is ignored.
